// File: rtl/lcd_pkg.sv
// Shared HD44780 bus definitions: read-mode encodings, controller timing, FSM states.
package lcd_pkg;

  localparam logic [1:0] MODO_STATUS = 2'b00;
  localparam logic [1:0] MODO_DADO   = 2'b01;
  localparam logic [1:0] MODO_ESPERA = 2'b10;

  // Controller minimums in ns; cycle counts are derived from these at 50 MHz
  localparam int CLK_PERIODO_NS = 20;
  localparam int T_AS_NS        = 40;
  localparam int T_EH_NS        = 230;
  localparam int T_CICLO_NS     = 500;

  typedef enum logic [2:0] {
    OCIOSO,
    PREP,
    EN_ALTO,
    EN_BAIXO,
    CICLO,
    VERIFICA,
    FIM
  } estado_t;

  // Mode 11 has no meaning of its own and behaves as a plain status read
  function automatic logic [1:0] modo_norm(input logic [1:0] m);
    return (m == 2'b11) ? MODO_STATUS : m;
  endfunction

endpackage

// File: rtl/lcd_leitor_status_if.sv
// Request/result and LCD read-path signals of the status reader.
interface lcd_leitor_status_if;
  logic       req;
  logic [1:0] modo;
  logic       pronto;
  logic       feito;
  logic [7:0] dado_lido;
  logic       busy_flag;
  logic [6:0] end_cont;
  logic       timeout;
  logic [7:0] lcd_data_in;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;
  logic       lcd_ativo;

  modport master (
    output req, modo, lcd_data_in,
    input  pronto, feito, dado_lido, busy_flag, end_cont, timeout,
    input  lcd_rs, lcd_rw, lcd_en, lcd_ativo
  );

  modport slave (
    input  req, modo, lcd_data_in,
    output pronto, feito, dado_lido, busy_flag, end_cont, timeout,
    output lcd_rs, lcd_rw, lcd_en, lcd_ativo
  );
endinterface

// File: rtl/lcd_ciclo_leitura.sv
// One HD44780 read strobe: setup, EN high (sample on last cycle), EN low recovery.
// RS/RW/ATIVO are taken on start and held until soltar, so polls keep the bus.
module lcd_ciclo_leitura
  import lcd_pkg::*;
#(
  parameter int T_AS_CYC = 3,
  parameter int T_EH_CYC = 12,
  parameter int T_EL_CYC = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rs,
  input  logic       soltar,
  input  logic [7:0] lcd_data_in,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic       lcd_ativo,
  output logic [7:0] dado,
  output logic       amostra,
  output logic       fim
);

  localparam logic [7:0] AS_ULT = 8'(T_AS_CYC - 1);
  localparam logic [7:0] EH_ULT = 8'(T_EH_CYC - 1);
  localparam logic [7:0] EL_ULT = 8'(T_EL_CYC - 1);

  estado_t    estado, estado_prox;
  logic [7:0] cnt, cnt_prox;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado <= OCIOSO;
      cnt    <= 8'd0;
      lcd_en <= 1'b0;
    end else begin
      estado <= estado_prox;
      cnt    <= cnt_prox;
      // EN comes straight from a flop so the strobe never glitches
      lcd_en <= (estado_prox == EN_ALTO);
    end
  end

  always_comb begin
    estado_prox = estado;
    cnt_prox    = cnt + 8'd1;
    amostra     = 1'b0;
    fim         = 1'b0;
    case (estado)
      OCIOSO: begin
        cnt_prox = 8'd0;
        if (start) estado_prox = PREP;
      end
      PREP: begin
        if (cnt == AS_ULT) begin
          estado_prox = EN_ALTO;
          cnt_prox    = 8'd0;
        end
      end
      EN_ALTO: begin
        if (cnt == EH_ULT) begin
          amostra     = 1'b1;
          estado_prox = EN_BAIXO;
          cnt_prox    = 8'd0;
        end
      end
      EN_BAIXO: begin
        if (cnt == EL_ULT) begin
          fim         = 1'b1;
          estado_prox = OCIOSO;
          cnt_prox    = 8'd0;
        end
      end
      default: begin
        estado_prox = OCIOSO;
        cnt_prox    = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lcd_rs    <= 1'b0;
      lcd_rw    <= 1'b0;
      lcd_ativo <= 1'b0;
    end else if (start) begin
      lcd_rs    <= rs;
      lcd_rw    <= 1'b1;
      lcd_ativo <= 1'b1;
    end else if (soltar) begin
      lcd_rs    <= 1'b0;
      lcd_rw    <= 1'b0;
      lcd_ativo <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          dado <= 8'h00;
    else if (amostra) dado <= lcd_data_in;
  end

endmodule

// File: rtl/lcd_leitor_status.sv
// HD44780 reader: status read, data read, or poll status until not busy / POLL_MAX reads.
module lcd_leitor_status
  import lcd_pkg::*;
#(
  parameter int T_AS_CYC = 3,
  parameter int T_EH_CYC = 12,
  parameter int T_EL_CYC = 15,
  parameter int POLL_MAX = 50000
) (
  input  logic                 clk,
  input  logic                 rst,
  lcd_leitor_status_if.slave   bus
);

  localparam logic [15:0] POLL_LIM = 16'(POLL_MAX);

  estado_t     estado, estado_prox;
  logic [1:0]  modo_q, modo_prox;
  logic [15:0] polls_q, polls_prox;
  logic        timeout_q, timeout_prox;
  logic        busy_q;
  logic [6:0]  end_q;
  logic        start, rs_sel, soltar, amostra, fim;

  lcd_ciclo_leitura #(
    .T_AS_CYC (T_AS_CYC),
    .T_EH_CYC (T_EH_CYC),
    .T_EL_CYC (T_EL_CYC)
  ) u_ciclo (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .rs          (rs_sel),
    .soltar      (soltar),
    .lcd_data_in (bus.lcd_data_in),
    .lcd_rs      (bus.lcd_rs),
    .lcd_rw      (bus.lcd_rw),
    .lcd_en      (bus.lcd_en),
    .lcd_ativo   (bus.lcd_ativo),
    .dado        (bus.dado_lido),
    .amostra     (amostra),
    .fim         (fim)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado    <= OCIOSO;
      modo_q    <= MODO_STATUS;
      polls_q   <= 16'd0;
      timeout_q <= 1'b0;
    end else begin
      estado    <= estado_prox;
      modo_q    <= modo_prox;
      polls_q   <= polls_prox;
      timeout_q <= timeout_prox;
    end
  end

  // Data reads leave the last status snapshot untouched
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      end_q  <= 7'd0;
    end else if (amostra && (modo_q != MODO_DADO)) begin
      busy_q <= bus.lcd_data_in[7];
      end_q  <= bus.lcd_data_in[6:0];
    end
  end

  always_comb begin
    estado_prox  = estado;
    modo_prox    = modo_q;
    polls_prox   = polls_q;
    timeout_prox = timeout_q;
    start        = 1'b0;
    soltar       = 1'b0;
    rs_sel       = (modo_q == MODO_DADO);
    bus.pronto   = 1'b0;
    bus.feito    = 1'b0;
    case (estado)
      OCIOSO: begin
        bus.pronto = 1'b1;
        rs_sel     = (modo_norm(bus.modo) == MODO_DADO);
        if (bus.req) begin
          start        = 1'b1;
          modo_prox    = modo_norm(bus.modo);
          polls_prox   = 16'd0;
          timeout_prox = 1'b0;
          estado_prox  = CICLO;
        end
      end
      CICLO: begin
        if (fim) estado_prox = VERIFICA;
      end
      VERIFICA: begin
        if ((modo_q != MODO_ESPERA) || !busy_q) begin
          soltar      = 1'b1;
          estado_prox = FIM;
        end else begin
          if (polls_q < POLL_LIM) polls_prox = polls_q + 16'd1;
          if (polls_prox == POLL_LIM) begin
            timeout_prox = 1'b1;
            soltar       = 1'b1;
            estado_prox  = FIM;
          end else begin
            start       = 1'b1;
            estado_prox = CICLO;
          end
        end
      end
      FIM: begin
        bus.feito   = 1'b1;
        estado_prox = OCIOSO;
      end
      default: estado_prox = OCIOSO;
    endcase
  end

  assign bus.busy_flag = busy_q;
  assign bus.end_cont  = end_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_lcd_leitor_status.sv
// Bench for lcd_leitor_status: bus model answers each EN pulse from a response queue.
module tb_lcd_leitor_status;

  localparam int POLL = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;

  lcd_leitor_status_if bus();

  lcd_leitor_status #(
    .T_AS_CYC (3),
    .T_EH_CYC (12),
    .T_EL_CYC (15),
    .POLL_MAX (POLL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int         vetores = 0;
  int         erros   = 0;
  logic [7:0] resp[$];
  logic [7:0] exp_dado = 8'h00;
  logic       exp_busy = 1'b0;
  logic [6:0] exp_end  = 7'h00;

  task automatic confere(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    vetores++;
    if (obs !== esp) begin
      erros++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, esp);
    end
  endtask

  // One complete operation; the expected outcome is worked out from the response list first.
  task automatic executa(input logic [1:0] modo, input bit injeta);
    logic [1:0] m;
    logic [7:0] ult;
    int n_exp, ciclo, pulsos, largura, primeira, erros_bus, idx, extra;
    bit to_exp, en_ant, achou, rs_exp;
    m = (modo == 2'b11) ? 2'b00 : modo;
    rs_exp = (m == 2'b01);
    n_exp = 0; to_exp = 0;
    if (m == 2'b10) begin
      for (int i = 0; i < resp.size(); i++) begin
        n_exp++;
        if (!resp[i][7]) break;
        if (n_exp == POLL) begin
          to_exp = 1;
          break;
        end
      end
    end else begin
      n_exp = 1;
    end
    ult = resp[n_exp-1];

    ciclo = 0; pulsos = 0; largura = 0; primeira = 0; erros_bus = 0; idx = 0; extra = 0;
    en_ant = 0; achou = 0;
    @(negedge clk);
    confere("pronto_antes", bus.pronto, 1);
    bus.modo = modo;
    bus.req  = 1'b1;
    @(posedge clk);
    #1;
    bus.req  = 1'b0;
    bus.modo = 2'($urandom);
    while (!achou && ciclo < 400) begin
      @(negedge clk);
      ciclo++;
      if (injeta && ciclo == 8) begin
        bus.req  = 1'b1;
        bus.modo = 2'b01;
      end
      if (injeta && ciclo == 9) bus.req = 1'b0;
      if (bus.lcd_en && !en_ant) begin
        pulsos++;
        if (pulsos == 1) primeira = ciclo;
        bus.lcd_data_in = (idx < resp.size()) ? resp[idx] : 8'h00;
        idx++;
        largura = 0;
      end
      if (bus.lcd_en) largura++;
      if (!bus.lcd_en && en_ant) begin
        confere("largura_en", largura, 12);
        bus.lcd_data_in = 8'($urandom);
      end
      if (bus.lcd_ativo && (bus.lcd_rs !== rs_exp || bus.lcd_rw !== 1'b1)) erros_bus++;
      en_ant = bus.lcd_en;
      if (bus.feito) achou = 1;
    end

    exp_dado = ult;
    if (m != 2'b01) begin
      exp_busy = ult[7];
      exp_end  = ult[6:0];
    end
    confere("feito", achou, 1);
    confere("latencia", ciclo, 1 + 31 * n_exp);
    confere("pulsos_en", pulsos, n_exp);
    confere("subida_en", primeira, 4);
    confere("rs_rw", erros_bus, 0);
    confere("dado_lido", bus.dado_lido, exp_dado);
    confere("busy_flag", bus.busy_flag, exp_busy);
    confere("end_cont", bus.end_cont, exp_end);
    confere("timeout", bus.timeout, to_exp);
    @(negedge clk);
    confere("feito_pulso", bus.feito, 0);
    confere("pronto_depois", bus.pronto, 1);
    confere("ativo_depois", bus.lcd_ativo, 0);
    if (injeta) begin
      repeat (40) begin
        @(negedge clk);
        if (bus.lcd_en || bus.lcd_ativo || bus.feito) extra++;
      end
      confere("sem_segunda_op", extra, 0);
    end
    resp.delete();
  endtask

  initial begin
    logic [1:0] md;
    int nb;
    bus.req = 1'b0;
    bus.modo = 2'b00;
    bus.lcd_data_in = 8'h00;
    repeat (2) @(negedge clk);
    confere("rst_pronto", bus.pronto, 1);
    confere("rst_feito", bus.feito, 0);
    confere("rst_bus", {bus.lcd_en, bus.lcd_rw, bus.lcd_rs, bus.lcd_ativo}, 0);
    confere("rst_dado", bus.dado_lido, 0);
    confere("rst_status", {bus.timeout, bus.busy_flag, bus.end_cont}, 0);
    rst = 1'b0;

    resp.push_back(8'h25);
    executa(2'b00, 0);
    resp.push_back(8'h41);
    executa(2'b01, 0);
    resp.push_back(8'h80); resp.push_back(8'h80); resp.push_back(8'h80); resp.push_back(8'h07);
    executa(2'b10, 0);
    repeat (POLL) resp.push_back(8'hFF);
    executa(2'b10, 0);
    resp.push_back(8'h25);
    executa(2'b00, 1);
    resp.push_back(8'h5A);
    executa(2'b11, 0);

    // Abort a read while EN is high
    @(negedge clk);
    bus.modo = 2'b00;
    bus.req  = 1'b1;
    @(posedge clk);
    #1;
    bus.req = 1'b0;
    repeat (7) @(negedge clk);
    confere("en_antes_reset", bus.lcd_en, 1);
    #2 rst = 1'b1;
    #1;
    confere("reset_assinc", {bus.lcd_en, bus.lcd_rw, bus.lcd_ativo}, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_dado = 8'h00; exp_busy = 1'b0; exp_end = 7'h00;
    @(negedge clk);
    confere("pos_reset_pronto", bus.pronto, 1);
    confere("pos_reset_dado", bus.dado_lido, 0);
    resp.push_back(8'h3C);
    executa(2'b00, 0);

    for (int t = 0; t < 24; t++) begin
      md = 2'($urandom_range(0, 3));
      if (md == 2'b10) begin
        nb = $urandom_range(0, 6);
        for (int j = 0; j < nb; j++) resp.push_back(8'h80 | 8'($urandom));
        resp.push_back(8'($urandom) & 8'h7F);
      end else begin
        resp.push_back(8'($urandom));
      end
      executa(md, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vetores, erros);
    $finish;
  end

endmodule

// File: doc/lcd_leitor_status.md
Name: lcd_leitor_status

Overview:
- Read-side companion to the HD44780 initialisation/write driver on the 8-bit LCD bus.
- Runs HD44780 read cycles (RW=1):
  - status read (RS=0): busy flag plus address counter;
  - data read (RS=1): DDRAM/CGRAM byte;
  - busy-wait mode: polls the status register until BF=0 or a timeout.
- Sits beside the writer; the top level muxes RS/RW/EN and tri-states LCD_DATA whenever LCD_ATIVO=1.

Parameters:
- T_AS_CYC, 3, cycles RS/RW are stable before EN rises (≥40 ns at 50 MHz).
- T_EH_CYC, 12, EN high width in cycles (≥230 ns); data sampled on the last cycle.
- T_EL_CYC, 15, EN low/recovery cycles before the cycle ends (EN cycle ≥500 ns).
- POLL_MAX, 50000, maximum status reads in busy-wait mode before timeout.

Ports:
- Clock  in  1  system clock, 50 MHz
- Reset  in  1  asynchronous, active-high reset
- REQ  in  1  start request; accepted only when PRONTO=1
- MODO  in  2  00 status read, 01 data read, 10 wait-not-busy, 11 treated as 00
- PRONTO  out  1  idle, ready to accept REQ
- FEITO  out  1  one-cycle pulse when the operation completes
- DADO_LIDO  out  8  last byte sampled from LCD_DATA_IN
- BUSY_FLAG  out  1  DADO_LIDO[7] of the last status read
- END_CONT  out  7  DADO_LIDO[6:0] of the last status read
- TIMEOUT  out  1  set with FEITO if wait mode hit POLL_MAX; cleared on next accept
- LCD_DATA_IN  in  8  LCD data pins (input path)
- LCD_RS  out  1  register select
- LCD_RW  out  1  1 = read
- LCD_EN  out  1  enable strobe
- LCD_ATIVO  out  1  this block owns the bus (top level tri-states data, selects these RS/RW/EN)

Behaviour:
- Reset (async, any state):
  - State goes to OCIOSO.
  - LCD_EN=0, LCD_RW=0, LCD_RS=0, LCD_ATIVO=0, PRONTO=1, FEITO=0, TIMEOUT=0.
  - DADO_LIDO=8'h00, BUSY_FLAG=0, END_CONT=0.
  - Counters cleared.
  - A read in progress is aborted; EN falls immediately.
- States:
  - OCIOSO
    - PRONTO=1.
    - On REQ, latch MODO, clear TIMEOUT and poll counter, go to PREP. REQ on any other cycle is ignored.
  - PREP (T_AS_CYC cycles)
    - LCD_ATIVO=1, LCD_RW=1, EN=0.
    - LCD_RS=1 for mode 01, 0 otherwise.
  - EN_ALTO (T_EH_CYC cycles)
    - EN=1.
    - On the last cycle, register LCD_DATA_IN into DADO_LIDO.
    - For status modes, also update BUSY_FLAG and END_CONT.
  - EN_BAIXO (T_EL_CYC cycles)
    - EN=0; RS/RW held; LCD_ATIVO=1.
  - VERIFICA (1 cycle)
    - Modes 00/01: go to FIM.
    - Mode 10:
      - BUSY_FLAG=0 → FIM.
      - Else increment poll counter; if it equals POLL_MAX, set TIMEOUT and go to FIM.
      - Otherwise go back to PREP.
  - FIM (1 cycle)
    - FEITO=1, LCD_ATIVO=0, RW=0, RS=0.
    - Next state OCIOSO.
- Latency with defaults:
  - REQ accepted at edge k; PREP begins k+1.
  - Single read: FEITO is high during cycle k+32 (3+12+15 cycles, +1 VERIFICA, +1 FIM).
  - Each extra poll adds 31 cycles.
- Outputs from PREP through the end of EN_BAIXO are registered and glitch-free. EN rises exactly T_AS_CYC cycles after RS/RW settle.
- DADO_LIDO, BUSY_FLAG and END_CONT persist until the next sample.
- Poll counter is 16 bits and saturates at POLL_MAX; POLL_MAX=1 gives exactly one read.
- REQ held high continuously: a new operation starts one cycle after FIM (OCIOSO accepts it).

Decomposition:
- Shared package lcd_pkg:
  - MODO encodings (MODO_STATUS, MODO_DADO, MODO_ESPERA);
  - HD44780 timing constants in ns;
  - a state enum shared with the writer FSM.
- One natural sub-module: lcd_ciclo_leitura.
  - Runs a single PREP/EN_ALTO/EN_BAIXO strobe sequence: inputs start and rs; outputs EN, sampled byte, fim.
  - lcd_leitor_status wraps it with mode and poll control.

Test Plan:
- Status read: MODO=00, bus model drives 8'h25 → RS=0, RW=1.
  - EN rises 3 cycles after PREP entry and stays high 12 cycles.
  - FEITO at k+32; BUSY_FLAG=0, END_CONT=7'h25.
- Data read: MODO=01, bus drives 8'h41 → RS=1 throughout the cycle; DADO_LIDO=8'h41; TIMEOUT=0.
- Busy-wait: model returns 8'h80 for 3 reads, then 8'h07.
  - Exactly 4 EN pulses; FEITO at k+1+4·31.
  - BUSY_FLAG=0, END_CONT=7'h07, TIMEOUT=0.
- Timeout: POLL_MAX=5, model always 8'hFF → 5 EN pulses, then FEITO with TIMEOUT=1 and BUSY_FLAG=1.
- Reset mid-read: assert Reset during EN_ALTO → EN, RW, LCD_ATIVO go to 0 asynchronously.
  - After release: PRONTO=1, DADO_LIDO=8'h00.
  - A new REQ completes normally.
- REQ ignored while busy: pulse REQ with MODO=01 during a mode 00 operation → no second operation; RS stays 0; only one FEITO pulse.
